// File: rtl/systolic_feed_ctrl_pkg.sv
// Shared state encoding and timing helpers for the systolic array feed controller.
package systolic_feed_ctrl_pkg;

  typedef logic [2:0] feed_state_t;

  localparam feed_state_t ST_IDLE  = 3'd0;
  localparam feed_state_t ST_FEED  = 3'd1;
  localparam feed_state_t ST_WAIT  = 3'd2;
  localparam feed_state_t ST_DRAIN = 3'd3;
  localparam feed_state_t ST_DONE  = 3'd4;

  // Cycles for the last injected vector to cross the skewed array and leave the PEs.
  function automatic int drain_wait(input int n, input int pe_lat);
    return 2 * (n - 1) + pe_lat;
  endfunction

endpackage

// File: rtl/systolic_feed_ctrl_feed_addr_gen.sv
// Operand buffer read sequencer: latches the base, walks k consecutive addresses
// (wrapping at the buffer size) and flags the final read to the controller FSM.
module feed_addr_gen #(
  parameter int MAX_K  = 256,
  parameter int BUF_AW = 8,
  parameter int KW     = $clog2(MAX_K + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KW-1:0]     k,
  input  logic [BUF_AW-1:0] base,
  output logic              rd_en,
  output logic [BUF_AW-1:0] rd_addr,
  output logic              last
);

  logic              active_reg;
  logic [KW-1:0]     j_reg;
  logic [KW-1:0]     k_reg;
  logic [BUF_AW-1:0] base_reg;
  logic [KW-1:0]     k_sat;

  // Out-of-range lengths are clamped so the read loop always terminates.
  always_comb begin
    k_sat = k;
    if (k > KW'(MAX_K)) k_sat = KW'(MAX_K);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_reg <= 1'b0;
      j_reg      <= '0;
      k_reg      <= '0;
      base_reg   <= '0;
    end else if (start) begin
      active_reg <= 1'b1;
      j_reg      <= '0;
      k_reg      <= k_sat;
      base_reg   <= base;
    end else if (active_reg) begin
      if (last) begin
        active_reg <= 1'b0;
        j_reg      <= '0;
      end else begin
        j_reg <= j_reg + KW'(1);
      end
    end
  end

  assign rd_en   = active_reg;
  assign rd_addr = active_reg ? (base_reg + BUF_AW'(j_reg)) : '0;
  assign last    = active_reg && (j_reg == (k_reg - KW'(1)));

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Tile sequencer for the N x N systolic array: feed operands, flush the skew
// chains, drain result rows, then pulse done.
module systolic_feed_ctrl
  import systolic_feed_ctrl_pkg::*;
#(
  parameter int N      = 4,
  parameter int MAX_K  = 256,
  parameter int PE_LAT = 1,
  parameter int BUF_AW = 8,
  parameter int KW     = $clog2(MAX_K + 1),
  parameter int RW     = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [KW-1:0]     cmd_k,
  input  logic [BUF_AW-1:0] cmd_base,
  input  logic              cmd_acc,
  output logic              buf_rd_en,
  output logic [BUF_AW-1:0] buf_rd_addr,
  output logic              feed_valid,
  output logic              array_clear,
  output logic              array_en,
  output logic              drain_valid,
  output logic [RW-1:0]     drain_row,
  output logic              busy,
  output logic              done
);

  localparam int DRAIN_WAIT = drain_wait(N, PE_LAT);
  localparam int WCW        = $clog2(DRAIN_WAIT + 1);

  feed_state_t    state_reg, state_next;
  logic [WCW-1:0] wait_cnt_reg;
  logic [RW-1:0]  drain_cnt_reg;
  logic           feed_valid_reg;
  logic           clear_pending_reg;
  logic           accept;
  logic           start;
  logic           last_rd;

  assign accept = cmd_valid && (state_reg == ST_IDLE);
  assign start  = accept && (cmd_k != '0);

  feed_addr_gen #(
    .MAX_K  (MAX_K),
    .BUF_AW (BUF_AW),
    .KW     (KW)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .k       (cmd_k),
    .base    (cmd_base),
    .rd_en   (buf_rd_en),
    .rd_addr (buf_rd_addr),
    .last    (last_rd)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (accept) state_next = (cmd_k != '0) ? ST_FEED : ST_DONE;
      ST_FEED:  if (last_rd) state_next = ST_WAIT;
      ST_WAIT:  if (wait_cnt_reg == WCW'(DRAIN_WAIT)) state_next = ST_DRAIN;
      ST_DRAIN: if (drain_cnt_reg == RW'(N - 1)) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= ST_IDLE;
      wait_cnt_reg      <= '0;
      drain_cnt_reg     <= '0;
      feed_valid_reg    <= 1'b0;
      clear_pending_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      feed_valid_reg <= buf_rd_en;
      // Counters run only while staying in their state, so each entry starts at zero.
      if (state_reg == ST_WAIT && state_next == ST_WAIT)
        wait_cnt_reg <= wait_cnt_reg + WCW'(1);
      else
        wait_cnt_reg <= '0;
      if (state_reg == ST_DRAIN && state_next == ST_DRAIN)
        drain_cnt_reg <= drain_cnt_reg + RW'(1);
      else
        drain_cnt_reg <= '0;
      if (accept)
        clear_pending_reg <= !cmd_acc;
      else if (feed_valid_reg)
        clear_pending_reg <= 1'b0;
    end
  end

  assign cmd_ready   = (state_reg == ST_IDLE);
  assign busy        = (state_reg != ST_IDLE);
  assign done        = (state_reg == ST_DONE);
  assign feed_valid  = feed_valid_reg;
  assign array_clear = feed_valid_reg && clear_pending_reg;
  // The WAIT window absorbs the read latency, so no separate tail term is needed.
  assign array_en    = (state_reg == ST_FEED && feed_valid_reg) || (state_reg == ST_WAIT);
  assign drain_valid = (state_reg == ST_DRAIN);
  assign drain_row   = drain_cnt_reg;

endmodule

// File: doc/systolic_feed_ctrl.md
Name: systolic_feed_ctrl

Overview:
- Sequences one matrix-multiply tile through the N x N systolic array.
- Accepts a command, generates operand-buffer reads that feed the per-row skew shift registers, and holds the array enabled while skewed data propagates.
- Then drains result rows one per cycle and reports completion.
- Sits between the MM command queue and the operand buffer / skew chain / PE array in the MM subsystem.

Parameters:
- N, 4, array dimension; row i skew depth is i.
- MAX_K, 256, maximum reduction length (vectors per tile).
- PE_LAT, 1, PE multiply-accumulate pipeline latency in cycles.
- BUF_AW, 8, operand buffer address width.
- Derived: KW = $clog2(MAX_K+1); RW = $clog2(N); DRAIN_WAIT = 2*(N-1)+PE_LAT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller idle and able to accept
- cmd_k  in  KW  reduction length; legal range 0..MAX_K
- cmd_base  in  BUF_AW  first operand buffer address
- cmd_acc  in  1  1 = accumulate onto existing PE sums; 0 = clear first
- buf_rd_en  out  1  operand buffer read strobe (read data 1 cycle later)
- buf_rd_addr  out  BUF_AW  operand buffer address
- feed_valid  out  1  buffer data valid into skew chain; datapath injects zero when low
- array_clear  out  1  clear PE accumulators (with first feed)
- array_en  out  1  PE array / skew chain advance enable
- drain_valid  out  1  result row valid on array output
- drain_row  out  RW  index of row being drained
- busy  out  1  not IDLE
- done  out  1  one-cycle tile-complete pulse

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high. Reset is sampled at posedge only.
- Reset, including mid-operation, forces state IDLE on the next edge and clears all counters and the feed_valid delay flop. All outputs are 0 except cmd_ready=1.
- States:
  - IDLE -> FEED on cmd_valid&&cmd_ready with cmd_k>0.
  - IDLE -> DONE when cmd_k==0: no reads, no drain, done still pulses.
  - FEED -> WAIT after cmd_k read cycles.
  - WAIT -> DRAIN after DRAIN_WAIT+1 cycles.
  - DRAIN -> DONE after N cycles.
  - DONE -> IDLE after 1 cycle.
- Handshake: cmd_ready = (state==IDLE). cmd_k, cmd_base and cmd_acc are latched on acceptance; later changes to these inputs are ignored.
- FEED:
  - buf_rd_en=1 each cycle.
  - buf_rd_addr = latched base + j, j=0..k-1, wrapping modulo 2^BUF_AW.
- feed_valid is buf_rd_en delayed by exactly one cycle.
- array_clear = feed_valid on the first feed cycle AND !acc. It is a single-cycle pulse.
- array_en = 1 from the first feed_valid cycle through the last WAIT cycle inclusive. WAIT's extra cycle absorbs the read latency, so zeros flush the skew chains.
- DRAIN:
  - drain_valid=1 for N consecutive cycles.
  - drain_row = 0,1,..,N-1.
  - array_en=0.
- DONE: done=1 for one cycle; busy=0 only in IDLE.
- Latency for k>0, acceptance at edge 0:
  - FEED cycles 1..k.
  - WAIT cycles k+1..k+DRAIN_WAIT+1.
  - DRAIN next N cycles.
  - done at cycle k+DRAIN_WAIT+N+2.
  - cmd_ready returns the following cycle.
- cmd_valid while busy is ignored; no queuing. Back-to-back commands are separated by at least one IDLE cycle.
- cmd_k > MAX_K is an illegal input: it is undefined but must not hang. The counter saturates at MAX_K.

Decomposition:
- Types.sv package gains a FeedState enum (IDLE, FEED, WAIT, DRAIN, DONE) and a function returning DRAIN_WAIT from N and PE_LAT.
- Scalar is unchanged and not used here.
- One natural sub-module: feed_addr_gen. It holds the base latch, the j counter, the wrapping address and rd_en, and signals last-read to the FSM.
- The FSM, wait/drain counters and output decode stay in the top module.

Test Plan:
- Basic tile, N=4, PE_LAT=1, k=3, base=0x10, acc=0:
  - rd_en cycles 1-3, addr 0x10,0x11,0x12.
  - feed_valid cycles 2-4; array_clear only cycle 2; array_en cycles 2-11.
  - drain_valid cycles 12-15, rows 0-3; done cycle 16; cmd_ready=1 cycle 17.
- Address wrap, base=0xFE, k=4: addr 0xFE,0xFF,0x00,0x01.
- acc=1, k=1: array_clear never asserted; done at cycle 1+7+4+2 = 14.
- k=0: done pulses cycle 1; rd_en, feed_valid, array_en and drain_valid stay 0 throughout.
- Reset at cycle 2 of FEED with k=5: next edge gives cmd_ready=1 and all other outputs 0. No done ever pulses, and a new command is accepted normally.
- cmd_valid held high with changing cmd_k during a tile: no second acceptance until after done, and addresses follow the latched values.
